// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32I opcode constants and the decoded-instruction bundle
// passed from the decoder to the ID/EX register.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_LUI  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } dec_t;

  // funct3 -> ALU op; alt selects sub/sra on the two funct3 codes that have one
  function automatic logic [3:0] f3_to_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I OP/OP-IMM/LUI/AUIPC decoder producing the ALU op,
// operands, destination and legality for one instruction.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output dec_t        dec
);

  logic [6:0]  opcode_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_u_s;
  logic [31:0] shamt_s;
  logic [3:0]  op_s;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic        legal_s;

  assign opcode_s = instr[6:0];
  assign f3_s     = instr[14:12];
  assign f7_s     = instr[31:25];
  assign imm_i_s  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u_s  = {instr[31:12], 12'h000};
  assign shamt_s  = {27'd0, instr[24:20]};

  // Raw decode before illegal-instruction override
  always_comb begin
    op_s    = ALU_ADD;
    a_s     = 32'h0000_0000;
    b_s     = 32'h0000_0000;
    legal_s = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        a_s  = rs1_data;
        b_s  = rs2_data;
        op_s = f3_to_op(f3_s, f7_s[5]);
        if (f7_s == F7_BASE) begin
          legal_s = 1'b1;
        end else if ((f7_s == F7_ALT) && ((f3_s == 3'b000) || (f3_s == 3'b101))) begin
          legal_s = 1'b1;
        end else begin
          legal_s = 1'b0;
        end
      end
      OPC_OPIMM: begin
        a_s = rs1_data;
        case (f3_s)
          3'b001: begin
            b_s     = shamt_s;
            op_s    = ALU_SLL;
            legal_s = (f7_s == F7_BASE);
          end
          3'b101: begin
            b_s     = shamt_s;
            op_s    = f7_s[5] ? ALU_SRA : ALU_SRL;
            legal_s = (f7_s == F7_BASE) || (f7_s == F7_ALT);
          end
          default: begin
            b_s     = imm_i_s;
            op_s    = f3_to_op(f3_s, 1'b0);
            legal_s = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        op_s    = ALU_LUI;
        a_s     = 32'h0000_0000;
        b_s     = imm_u_s;
        legal_s = 1'b1;
      end
      OPC_AUIPC: begin
        op_s    = ALU_ADD;
        a_s     = pc;
        b_s     = imm_u_s;
        legal_s = 1'b1;
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  // Illegal instructions travel as a harmless add of zeros with no write-back
  assign dec.op      = legal_s ? op_s : ALU_ADD;
  assign dec.a       = legal_s ? a_s : 32'h0000_0000;
  assign dec.b       = legal_s ? b_s : 32'h0000_0000;
  assign dec.rd      = instr[11:7];
  assign dec.wb_en   = legal_s && (instr[11:7] != 5'd0);
  assign dec.illegal = !legal_s;

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX valid/ready register between register-file read and the ALU; holds one
// decoded entry with stall backpressure, flush and full-throughput replacement.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      ALUopcode,
  output logic [XLEN-1:0] ALUin_a,
  output logic [XLEN-1:0] ALUin_b,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  dec_t        dec_s;
  dec_t        entry_r;
  logic [31:0] pc_r;
  logic        valid_r;
  logic        capture_s;

  alu_decoder u_dec (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dec      (dec_s)
  );

  assign in_ready  = !valid_r || out_ready;
  assign capture_s = in_valid && in_ready && !flush;

  // Pipeline register: flush beats capture, capture beats drain, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      entry_r <= '{op: ALU_ADD, a: 32'h0000_0000, b: 32'h0000_0000,
                   rd: 5'd0, wb_en: 1'b0, illegal: 1'b0};
      pc_r    <= RESET_PC;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (capture_s) begin
      valid_r <= 1'b1;
      entry_r <= dec_s;
      pc_r    <= pc;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end
  end

  assign out_valid   = valid_r;
  assign ALUopcode   = entry_r.op;
  assign ALUin_a     = entry_r.a;
  assign ALUin_b     = entry_r.b;
  assign out_rd      = entry_r.rd;
  assign out_wb_en   = entry_r.wb_en;
  assign out_illegal = entry_r.illegal;
  assign out_pc      = pc_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and randomized bench for alu_issue_stage against a one-slot
// reference model decoded from the RV32I field rules.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [3:0]  ALUopcode;
  logic [31:0] ALUin_a, ALUin_b, out_pc;
  logic [4:0]  out_rd;
  logic        out_wb_en, out_illegal;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  exp_t m;

  alu_issue_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ALUopcode(ALUopcode), .ALUin_a(ALUin_a), .ALUin_b(ALUin_b),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .out_illegal(out_illegal),
    .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  function automatic exp_t reset_entry();
    exp_t e;
    e.valid = 1'b0; e.op = 4'd0; e.a = 32'd0; e.b = 32'd0;
    e.rd = 5'd0; e.wb = 1'b0; e.ill = 1'b0; e.pc = 32'h0000_0000;
    return e;
  endfunction

  // Reference decode from the instruction-set field rules
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] ipc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    int   tab[8];
    int   f3, f7;
    bit   legal;
    tab = '{0, 6, 9, 10, 4, 7, 5, 3};
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    e = reset_entry();
    e.valid = 1'b1;
    e.pc = ipc;
    e.rd = ins[11:7];
    legal = 1'b0;
    case (ins[6:0])
      7'h33: begin
        e.a = r1; e.b = r2;
        if (f7 == 0) begin legal = 1'b1; e.op = 4'(tab[f3]); end
        else if (f7 == 32 && f3 == 0) begin legal = 1'b1; e.op = 4'd1; end
        else if (f7 == 32 && f3 == 5) begin legal = 1'b1; e.op = 4'd8; end
      end
      7'h13: begin
        e.a = r1;
        e.b = 32'($signed(ins[31:20]));
        e.op = 4'(tab[f3]);
        legal = 1'b1;
        if (f3 == 1) begin
          e.b = 32'(ins[24:20]);
          legal = (f7 == 0);
        end else if (f3 == 5) begin
          e.b = 32'(ins[24:20]);
          legal = (f7 == 0) || (f7 == 32);
          e.op = (f7 == 32) ? 4'd8 : 4'd7;
        end
      end
      7'h37: begin legal = 1'b1; e.op = 4'd2; e.a = 32'd0; e.b = ins[31:12] * 32'h1000; end
      7'h17: begin legal = 1'b1; e.op = 4'd0; e.a = ipc; e.b = ins[31:12] * 32'h1000; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.op = 4'd0; e.a = 32'd0; e.b = 32'd0; e.wb = 1'b0; e.ill = 1'b1;
    end else begin
      e.wb = (e.rd != 5'd0); e.ill = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(m.valid));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(!m.valid || out_ready));
    chk({tag, "_op"}, 32'(ALUopcode), 32'(m.op));
    chk({tag, "_a"}, ALUin_a, m.a);
    chk({tag, "_b"}, ALUin_b, m.b);
    chk({tag, "_rd"}, 32'(out_rd), 32'(m.rd));
    chk({tag, "_wb"}, 32'(out_wb_en), 32'(m.wb));
    chk({tag, "_ill"}, 32'(out_illegal), 32'(m.ill));
    chk({tag, "_pc"}, out_pc, m.pc);
  endtask

  // One clock: the model applies the transfer rules, then outputs are compared
  task automatic tick(input string tag);
    exp_t d;
    @(posedge clk);
    if (flush) begin
      m.valid = 1'b0;
    end else if (in_valid && (!m.valid || out_ready)) begin
      d = ref_decode(instr, pc, rs1_data, rs2_data);
      m = d;
    end else if (out_ready) begin
      m.valid = 1'b0;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    in_valid = v; instr = ins; out_ready = rdy; flush = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] f7;
    logic [6:0] opc;
    int sel;
    sel = $urandom_range(0, 4);
    case ($urandom_range(0, 3))
      0:       f7 = 7'($urandom);
      1:       f7 = 7'h20;
      default: f7 = 7'h00;
    endcase
    case (sel)
      0:       opc = 7'h33;
      1:       opc = 7'h13;
      2:       opc = 7'h37;
      3:       opc = 7'h17;
      default: opc = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    pc = 32'h0000_1000; rs1_data = 32'h8000_0000; rs2_data = 32'h8000_0000;
    m = reset_entry();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // add x3,x1,x2
    drive(1'b1, 32'h0020_81B3, 1'b1, 1'b0);
    tick("add");
    chk("add_op_c", 32'(ALUopcode), 32'd0);
    chk("add_rd_c", 32'(out_rd), 32'd3);
    chk("add_aluout", alu_ref(ALUopcode, ALUin_a, ALUin_b), 32'h0000_0000);

    // sub
    rs1_data = 32'h70F0_C0E0; rs2_data = 32'h1000_3054;
    drive(1'b1, 32'h4020_81B3, 1'b1, 1'b0);
    tick("sub");
    chk("sub_op_c", 32'(ALUopcode), 32'd1);
    chk("sub_aluout", alu_ref(ALUopcode, ALUin_a, ALUin_b), 32'h60F0_908C);

    // lui then srai
    drive(1'b1, 32'h1234_52B7, 1'b1, 1'b0);
    tick("lui");
    chk("lui_b_c", ALUin_b, 32'h1234_5000);
    chk("lui_rd_c", 32'(out_rd), 32'd5);
    drive(1'b1, 32'h4043_D313, 1'b1, 1'b0);
    tick("srai");
    chk("srai_op_c", 32'(ALUopcode), 32'd8);
    chk("srai_b_c", ALUin_b, 32'h0000_0004);

    // Backpressure: entry held for three cycles while a new one waits
    pc = 32'h0000_2000;
    drive(1'b1, 32'h0020_81B3, 1'b1, 1'b0);
    tick("bp_load");
    pc = 32'h0000_2004;
    drive(1'b1, 32'h0030_C233, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick("bp_hold");
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_pc_held", out_pc, 32'h0000_2000);
    end
    out_ready = 1'b1;
    tick("bp_release");
    chk("bp_next_pc", out_pc, 32'h0000_2004);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    tick("bp_drain");

    // Flush on a capture cycle, then asynchronous reset during a hold
    drive(1'b1, 32'h0020_81B3, 1'b1, 1'b1);
    tick("flush");
    chk("flush_valid_c", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h1234_52B7, 1'b0, 1'b0);
    tick("pre_rst");
    in_valid = 1'b0;
    #2 rst = 1'b1;
    m = reset_entry();
    #1 check_all("async_rst");
    chk("rst_valid_c", 32'(out_valid), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Illegal encodings
    drive(1'b1, 32'h0000_007F, 1'b1, 1'b0);
    tick("ill_7f");
    chk("ill_flag_c", 32'(out_illegal), 32'd1);
    chk("ill_wb_c", 32'(out_wb_en), 32'd0);
    drive(1'b1, {7'b0100000, 5'd3, 5'd1, 3'b001, 5'd4, 7'b0010011}, 1'b1, 1'b0);
    tick("ill_slli");
    chk("slli_ill_c", 32'(out_illegal), 32'd1);
    chk("slli_op_c", 32'(ALUopcode), 32'd0);

    // Randomized traffic with random stalls and flushes
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      instr     = rand_instr();
      pc        = $urandom;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
